// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the block-RAM arbiter: FSM state encodings and
//   the wait-counter width. Imported by the RTL and by the bench, which uses
//   the state names for its state probes.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_CORE   = 2'd0,
        ST_M1SLOT = 2'd1,
        ST_REPLAY = 2'd2
    } arb_state_t;

    localparam int WAIT_W = 8;

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// arb_wait_counter
//   Counts consecutive cycles of an M1 request, saturating at MAX_WAIT.
//   Any cycle without a request, or a clear (the grant slot), returns the
//   count to zero.
// Ports
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_req            M1 request level
//   i_clear          force the count to zero next cycle
//   o_cnt            current wait count
//   o_at_limit       o_cnt has reached MAX_WAIT
module arb_wait_counter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req,
    input  logic              i_clear,
    output logic [WAIT_W-1:0] o_cnt,
    output logic              o_at_limit
);

    localparam logic [WAIT_W-1:0] LIMIT = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (i_clear || !i_req) begin
            cnt_q <= '0;
        end else if (cnt_q != LIMIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_cnt      = cnt_q;
    assign o_at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one block-RAM between the core (M0, priority) and a secondary
//   requester M1 (boot loader / DMA). After M1 has waited MAX_WAIT request
//   cycles it is given one RAM slot; the core is held for that cycle and the
//   read data it had pending is replayed from a skid register the cycle after.
//
//   Optional build macro: MEM_ARBITER_STATS_EN adds o_stat_grants (saturating
//   grant count) and o_stat_maxwait (largest wait count seen at a grant).
//
// Ports
//   i_clk, i_reset                       clock, synchronous active-high reset
//   i_core_raddr / o_core_rdata          core read port
//   i_core_waddr / i_core_wdata / i_core_we  core write port
//   o_core_hold                          core must freeze this cycle
//   i_m1_req / i_m1_we / i_m1_addr / i_m1_wdata  M1 request
//   o_m1_gnt / o_m1_rvalid / o_m1_rdata  M1 grant and read return
//   o_ram_*  / i_ram_rdata               RAM (1-cycle read latency)
//
// State   | meaning
// --------+-----------------------------------------------------------------
// CORE    | core owns the RAM; M1 wait count runs
// M1SLOT  | M1 owns the RAM for this cycle; core held (decided combinationally)
// REPLAY  | core re-presents its access; core sees skid data; M1 read returns
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_core_raddr,
    output logic [DATA_W-1:0] o_core_rdata,
    input  logic [ADDR_W-1:0] i_core_waddr,
    input  logic [DATA_W-1:0] i_core_wdata,
    input  logic              i_core_we,
    output logic              o_core_hold,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic [ADDR_W-1:0] o_ram_raddr,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic [ADDR_W-1:0] o_ram_waddr,
    output logic [DATA_W-1:0] o_ram_wdata,
`ifdef MEM_ARBITER_STATS_EN
    output logic [15:0]       o_stat_grants,
    output logic [7:0]        o_stat_maxwait,
`endif
    output logic              o_ram_we
);

    arb_state_t        state_q;
    arb_state_t        cur_st;
    logic              slot;
    logic [DATA_W-1:0] skid;
    logic [WAIT_W-1:0] wait_cnt;
    logic              at_limit;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_req      (i_m1_req),
        .i_clear    (slot),
        .o_cnt      (wait_cnt),
        .o_at_limit (at_limit)
    );

    // The grant is decided in the same cycle the limit is reached, so the
    // M1 slot is never a registered state: state_q only holds CORE or REPLAY
    // and cur_st is the effective state seen by the muxes (and by probes).
    assign slot   = (state_q == ST_CORE) && i_m1_req && at_limit;
    assign cur_st = slot ? ST_M1SLOT : state_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_CORE;
            skid        <= '0;
            o_m1_rvalid <= 1'b0;
        end else begin
            o_m1_rvalid <= 1'b0;
            case (cur_st)
                ST_M1SLOT: begin
                    state_q     <= ST_REPLAY;
                    skid        <= i_ram_rdata;
                    o_m1_rvalid <= !i_m1_we;
                end
                ST_REPLAY: state_q <= ST_CORE;
                default:   state_q <= ST_CORE;
            endcase
        end
    end

    always_comb begin
        o_ram_raddr = i_core_raddr;
        o_ram_waddr = i_core_waddr;
        o_ram_wdata = i_core_wdata;
        o_ram_we    = i_core_we;
        if (slot) begin
            o_ram_raddr = i_m1_addr;
            o_ram_waddr = i_m1_addr;
            o_ram_wdata = i_m1_wdata;
            o_ram_we    = i_m1_req & i_m1_we;
        end
    end

    assign o_core_rdata = (state_q == ST_REPLAY) ? skid : i_ram_rdata;
    assign o_core_hold  = slot;
    assign o_m1_gnt     = slot;
    assign o_m1_rdata   = i_ram_rdata;

`ifdef MEM_ARBITER_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_stat_grants  <= '0;
            o_stat_maxwait <= '0;
        end else if (slot) begin
            if (o_stat_grants != 16'hFFFF) begin
                o_stat_grants <= o_stat_grants + 1'b1;
            end
            if (wait_cnt > o_stat_maxwait) begin
                o_stat_maxwait <= wait_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed bench for mem_arbiter. u_dut uses MAX_WAIT=4; u_dz uses
//   MAX_WAIT=0 for the alternating-slot program test. Each DUT has its own
//   RAM model with a one-cycle read latency. Optional macro:
//   MEM_ARBITER_STATS_EN (stats ports checked when defined).
`timescale 1ns/1ps
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // DUT with MAX_WAIT = 4
    logic [15:0] core_raddr, core_rdata, core_waddr, core_wdata;
    logic        core_we, core_hold;
    logic        m1_req, m1_we, m1_gnt, m1_rvalid;
    logic [15:0] m1_addr, m1_wdata, m1_rdata;
    logic [15:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata;
    logic        ram_we;
`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] stat_grants;
    logic [7:0]  stat_maxwait;
`endif
    logic [15:0] mem_a [0:65535];

    // DUT with MAX_WAIT = 0
    logic [15:0] z_core_raddr, z_core_rdata;
    logic        z_core_hold;
    logic        z_m1_req, z_m1_gnt, z_m1_rvalid;
    logic [15:0] z_m1_addr, z_m1_rdata;
    logic [15:0] z_ram_raddr, z_ram_rdata, z_ram_waddr, z_ram_wdata;
    logic        z_ram_we;
`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] z_stat_grants;
    logic [7:0]  z_stat_maxwait;
`endif
    logic [15:0] mem_z [0:65535];

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(4)) u_dut (
        .i_clk(clk), .i_reset(rst),
        .i_core_raddr(core_raddr), .o_core_rdata(core_rdata),
        .i_core_waddr(core_waddr), .i_core_wdata(core_wdata), .i_core_we(core_we),
        .o_core_hold(core_hold),
        .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
        .o_m1_gnt(m1_gnt), .o_m1_rvalid(m1_rvalid), .o_m1_rdata(m1_rdata),
        .o_ram_raddr(ram_raddr), .i_ram_rdata(ram_rdata),
        .o_ram_waddr(ram_waddr), .o_ram_wdata(ram_wdata),
`ifdef MEM_ARBITER_STATS_EN
        .o_stat_grants(stat_grants), .o_stat_maxwait(stat_maxwait),
`endif
        .o_ram_we(ram_we)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(0)) u_dz (
        .i_clk(clk), .i_reset(rst),
        .i_core_raddr(z_core_raddr), .o_core_rdata(z_core_rdata),
        .i_core_waddr(16'h0), .i_core_wdata(16'h0), .i_core_we(1'b0),
        .o_core_hold(z_core_hold),
        .i_m1_req(z_m1_req), .i_m1_we(1'b0), .i_m1_addr(z_m1_addr), .i_m1_wdata(16'h0),
        .o_m1_gnt(z_m1_gnt), .o_m1_rvalid(z_m1_rvalid), .o_m1_rdata(z_m1_rdata),
        .o_ram_raddr(z_ram_raddr), .i_ram_rdata(z_ram_rdata),
        .o_ram_waddr(z_ram_waddr), .o_ram_wdata(z_ram_wdata),
`ifdef MEM_ARBITER_STATS_EN
        .o_stat_grants(z_stat_grants), .o_stat_maxwait(z_stat_maxwait),
`endif
        .o_ram_we(z_ram_we)
    );

    always @(posedge clk) begin
        if (ram_we) mem_a[ram_waddr] <= ram_wdata;
        ram_rdata <= mem_a[ram_raddr];
        if (z_ram_we) mem_z[z_ram_waddr] <= z_ram_wdata;
        z_ram_rdata <= mem_z[z_ram_raddr];
    end

    task automatic test_reset();
        rst = 1'b1;
        core_raddr = 16'h0; core_waddr = 16'h0; core_wdata = 16'h0; core_we = 1'b0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 16'h0; m1_wdata = 16'h0;
        z_core_raddr = 16'h0; z_m1_req = 1'b0; z_m1_addr = 16'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (core_hold !== 1'b0) begin miscompares++; $display("FAIL reset_hold got %b exp 0", core_hold); end
        vectors++;
        if (m1_rvalid !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %b exp 0", m1_rvalid); end
        vectors++;
        if (u_dut.cur_st !== ST_CORE) begin miscompares++; $display("FAIL reset_state got %0d exp %0d", u_dut.cur_st, ST_CORE); end
        vectors++;
        if (u_dut.wait_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_wait_cnt got %0d exp 0", u_dut.wait_cnt); end
        @(negedge clk);
    endtask

    task automatic test_core_passthru();
        int holds = 0;
        core_raddr = 16'h0010;
        #1;
        vectors++;
        if (ram_raddr !== 16'h0010) begin miscompares++; $display("FAIL pass_raddr got %h exp 0010", ram_raddr); end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (core_hold) holds++;
        end
        vectors++;
        if (holds !== 0) begin miscompares++; $display("FAIL pass_hold_count got %0d exp 0", holds); end
        vectors++;
        if (core_rdata !== 16'hA5A5) begin miscompares++; $display("FAIL pass_rdata got %h exp a5a5", core_rdata); end
        @(negedge clk);
    endtask

    task automatic test_m1_read();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0200;
        for (int i = 1; i <= 4; i++) begin
            #1;
            vectors++;
            if (m1_gnt !== 1'b0) begin miscompares++; $display("FAIL rd_early_gnt cycle %0d got %b exp 0", i, m1_gnt); end
            @(negedge clk);
        end
        #1;
        vectors++;
        if (m1_gnt !== 1'b1 || core_hold !== 1'b1) begin miscompares++; $display("FAIL rd_gnt_hold got gnt=%b hold=%b exp 1/1", m1_gnt, core_hold); end
        vectors++;
        if (ram_raddr !== 16'h0200) begin miscompares++; $display("FAIL rd_slot_raddr got %h exp 0200", ram_raddr); end
        @(negedge clk);
        m1_req = 1'b0;
        #1;
        vectors++;
        if (m1_rvalid !== 1'b1 || m1_rdata !== 16'hBEEF) begin miscompares++; $display("FAIL rd_return got v=%b d=%h exp 1/beef", m1_rvalid, m1_rdata); end
        vectors++;
        if (core_rdata !== 16'hA5A5 || core_hold !== 1'b0) begin miscompares++; $display("FAIL rd_skid got d=%h hold=%b exp a5a5/0", core_rdata, core_hold); end
        @(negedge clk); #1;
        vectors++;
        if (m1_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_rvalid_pulse got %b exp 0", m1_rvalid); end
        @(negedge clk);
    endtask

    task automatic test_write_order();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 16'h0300; m1_wdata = 16'h1234;
        repeat (4) @(negedge clk);
        core_we = 1'b1; core_waddr = 16'h0300; core_wdata = 16'h5678;
        #1;
        vectors++;
        if (m1_gnt !== 1'b1 || ram_we !== 1'b1 || ram_waddr !== 16'h0300 || ram_wdata !== 16'h1234) begin
            miscompares++; $display("FAIL wr_slot got gnt=%b we=%b a=%h d=%h exp 1/1/0300/1234", m1_gnt, ram_we, ram_waddr, ram_wdata);
        end
        @(negedge clk);
        m1_req = 1'b0;
        #1;
        vectors++;
        if (mem_a[16'h0300] !== 16'h1234) begin miscompares++; $display("FAIL wr_after_slot got %h exp 1234", mem_a[16'h0300]); end
        vectors++;
        if (u_dut.cur_st !== ST_REPLAY || ram_we !== 1'b1 || ram_wdata !== 16'h5678) begin
            miscompares++; $display("FAIL wr_replay got st=%0d we=%b d=%h exp %0d/1/5678", u_dut.cur_st, ram_we, ram_wdata, ST_REPLAY);
        end
        vectors++;
        if (m1_rvalid !== 1'b0) begin miscompares++; $display("FAIL wr_no_rvalid got %b exp 0", m1_rvalid); end
        @(negedge clk);
        core_we = 1'b0;
        #1;
        vectors++;
        if (mem_a[16'h0300] !== 16'h5678) begin miscompares++; $display("FAIL wr_final got %h exp 5678", mem_a[16'h0300]); end
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0200;
        repeat (2) @(negedge clk);
        m1_req = 1'b0;
        #1;
        vectors++;
        if (m1_gnt !== 1'b0) begin miscompares++; $display("FAIL drop_gnt got %b exp 0", m1_gnt); end
        @(negedge clk); #1;
        vectors++;
        if (u_dut.wait_cnt !== 8'd0) begin miscompares++; $display("FAIL drop_wait_cnt got %0d exp 0", u_dut.wait_cnt); end
        @(negedge clk);
        m1_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            vectors++;
            if (m1_gnt !== 1'b0) begin miscompares++; $display("FAIL drop_regnt_early cycle %0d got %b exp 0", i, m1_gnt); end
            @(negedge clk);
        end
        #1;
        vectors++;
        if (m1_gnt !== 1'b1) begin miscompares++; $display("FAIL drop_regnt got %b exp 1", m1_gnt); end
        @(negedge clk);
        m1_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] prog_addr [10];
        logic [15:0] res [10];
        int pc = 0;
        int gnts = 0;
        for (int i = 0; i < 10; i++) begin
            prog_addr[i] = 16'h0400 + 16'(3 * i);
            res[i] = 16'h0;
        end
        z_m1_addr = 16'h0050;
        z_m1_req = 1'b1;
        for (int cyc = 0; cyc < 40 && pc < 11; cyc++) begin
            z_core_raddr = (pc < 10) ? prog_addr[pc] : 16'h0;
            #1;
            if (z_m1_gnt) gnts++;
            if (z_m1_rvalid) begin
                vectors++;
                if (z_m1_rdata !== 16'h7E7E) begin miscompares++; $display("FAIL b2b_m1_rdata cyc %0d got %h exp 7e7e", cyc, z_m1_rdata); end
            end
            if (!z_core_hold) begin
                if (pc > 0) res[pc-1] = z_core_rdata;
                pc++;
            end
            if (cyc == 19) begin
                vectors++;
                if (pc !== 10 || gnts !== 10) begin miscompares++; $display("FAIL b2b_20cyc got pc=%0d gnts=%0d exp 10/10", pc, gnts); end
            end
            @(negedge clk);
        end
        z_m1_req = 1'b0;
        vectors++;
        if (pc !== 11) begin miscompares++; $display("FAIL b2b_timeout got pc=%0d exp 11", pc); end
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (res[i] !== (16'h1000 + 16'(i * 16'h0111))) begin
                miscompares++; $display("FAIL b2b_result %0d got %h exp %h", i, res[i], 16'h1000 + 16'(i * 16'h0111));
            end
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_slot();
`ifdef MEM_ARBITER_STATS_EN
        #1;
        vectors++;
        if (stat_grants !== 16'd3 || stat_maxwait !== 8'd4) begin
            miscompares++; $display("FAIL stats_pre got g=%0d m=%0d exp 3/4", stat_grants, stat_maxwait);
        end
        @(negedge clk);
`endif
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 16'h0200;
        repeat (4) @(negedge clk);
        #1;
        vectors++;
        if (m1_gnt !== 1'b1) begin miscompares++; $display("FAIL rst_slot_gnt got %b exp 1", m1_gnt); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m1_req = 1'b0;
        #1;
        vectors++;
        if (u_dut.cur_st !== ST_CORE || m1_rvalid !== 1'b0 || core_hold !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_slot got st=%0d rv=%b hold=%b exp %0d/0/0", u_dut.cur_st, m1_rvalid, core_hold, ST_CORE);
        end
        vectors++;
        if (u_dut.skid !== 16'h0) begin miscompares++; $display("FAIL rst_skid got %h exp 0000", u_dut.skid); end
`ifdef MEM_ARBITER_STATS_EN
        vectors++;
        if (stat_grants !== 16'd0 || stat_maxwait !== 8'd0) begin
            miscompares++; $display("FAIL stats_post got g=%0d m=%0d exp 0/0", stat_grants, stat_maxwait);
        end
`endif
        @(negedge clk);
    endtask

    initial begin
        mem_a[16'h0010] = 16'hA5A5;
        mem_a[16'h0200] = 16'hBEEF;
        mem_a[16'h0300] = 16'h0000;
        mem_z[16'h0050] = 16'h7E7E;
        for (int i = 0; i < 10; i++) mem_z[16'h0400 + 16'(3 * i)] = 16'h1000 + 16'(i * 16'h0111);
        test_reset();
        test_core_passthru();
        test_m1_read();
        test_write_order();
        test_drop_req();
        test_back_to_back();
        test_reset_mid_slot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
